// File: rtl/game_pkg.sv
// Shared op codes and default sizing for the game undo/redo history blocks.
package game_pkg;

  localparam logic [1:0] OP_LOAD    = 2'd0;
  localparam logic [1:0] OP_PUSH_BM = 2'd1;
  localparam logic [1:0] OP_PUSH_MM = 2'd2;
  localparam logic [1:0] OP_UNDO    = 2'd3;

  localparam int GAME_STATE_W    = 134;
  localparam int GAME_UNDO_DEPTH = 3;

endpackage

// File: rtl/game_hist_stack.sv
// W x DEPTH LIFO of game-state snapshots with a saturating count.
// A push onto a full stack discards the oldest entry.
module game_hist_stack #(
  parameter int W     = 134,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] cnt
);

  logic [W-1:0] mem [DEPTH];

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c == CW'(DEPTH)) return c;
    return c + CW'(1);
  endfunction

  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
    if (c == '0) return c;
    return c - CW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      cnt <= '0;
    end else if (clear) begin
      // Entries are left as-is; a zero count makes them unreachable.
      cnt <= '0;
    end else if (push) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      cnt <= sat_inc(cnt);
    end else if (pop && cnt != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      mem[DEPTH-1] <= '0;
      cnt <= sat_dec(cnt);
    end
  end

  assign top = mem[0];

endmodule

// File: rtl/game_undo_stack.sv
// Live game state plus bounded undo history; optional redo stack when
// GAME_UNDO_REDO_EN is defined.
module game_undo_stack
  import game_pkg::*;
#(
  parameter int W     = GAME_STATE_W,
  parameter int DEPTH = GAME_UNDO_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    sel,
  input  logic [W-1:0]  state_init,
  input  logic [W-1:0]  state_bm,
  input  logic [W-1:0]  state_mm,
  output logic [W-1:0]  game_state,
  output logic [CW-1:0] undo_cnt,
  output logic          undo_avail
`ifdef GAME_UNDO_REDO_EN
  ,
  input  logic          redo,
  output logic [CW-1:0] redo_cnt
`endif
);

  logic [W-1:0] state_nxt;
  logic [W-1:0] undo_top;
  logic         u_push, u_pop, u_clear;
`ifdef GAME_UNDO_REDO_EN
  logic [W-1:0] redo_top;
  logic         r_push, r_pop, r_clear;
`endif

  always_comb begin
    state_nxt = game_state;
    u_push    = 1'b0;
    u_pop     = 1'b0;
    u_clear   = 1'b0;
`ifdef GAME_UNDO_REDO_EN
    r_push    = 1'b0;
    r_pop     = 1'b0;
    r_clear   = 1'b0;
    if (en && redo) begin
      // Redo overrides sel for the cycle, even when there is nothing to redo.
      if (redo_cnt != '0) begin
        state_nxt = redo_top;
        u_push    = 1'b1;
        r_pop     = 1'b1;
      end
    end else
`endif
    if (en) begin
      case (sel)
        OP_LOAD: begin
          state_nxt = state_init;
          u_clear   = 1'b1;
`ifdef GAME_UNDO_REDO_EN
          r_clear   = 1'b1;
`endif
        end
        OP_PUSH_BM, OP_PUSH_MM: begin
          state_nxt = (sel == OP_PUSH_BM) ? state_bm : state_mm;
          u_push    = 1'b1;
`ifdef GAME_UNDO_REDO_EN
          r_clear   = 1'b1;
`endif
        end
        default: begin
          if (undo_cnt != '0) begin
            state_nxt = undo_top;
            u_pop     = 1'b1;
`ifdef GAME_UNDO_REDO_EN
            r_push    = 1'b1;
`endif
          end
        end
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) game_state <= '0;
    else        game_state <= state_nxt;
  end

  game_hist_stack #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_undo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (u_push),
    .pop   (u_pop),
    .clear (u_clear),
    .din   (game_state),
    .top   (undo_top),
    .cnt   (undo_cnt)
  );

`ifdef GAME_UNDO_REDO_EN
  game_hist_stack #(.W(W), .DEPTH(DEPTH), .CW(CW)) u_redo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_push),
    .pop   (r_pop),
    .clear (r_clear),
    .din   (game_state),
    .top   (redo_top),
    .cnt   (redo_cnt)
  );
`endif

  assign undo_avail = (undo_cnt != '0);

endmodule

// File: doc/game_undo_stack.md
Name: game_undo_stack

Overview:
- Parametrised successor of the fixed 3-step retract block.
- Holds the live game state plus up to DEPTH prior snapshots, with configurable state width W.
- Tracks how many undo steps are valid, so undoing past the oldest snapshot is refused instead of restoring stale data.
- Sits between the move/box logic and the renderer. Drives game_state to both.

Parameters:
- W, 134, width of one game-state snapshot.
- DEPTH, 3, number of undo snapshots retained (≥1).
- CW, $clog2(DEPTH+1), width of the valid-entry counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  operation strobe; nothing changes when low.
- sel  in  2  op: 0=LOAD (level init), 1=PUSH_BM (box move), 2=PUSH_MM (man move), 3=UNDO.
- state_init  in  W  level initial state.
- state_bm  in  W  next state after a box move.
- state_mm  in  W  next state after a man move.
- game_state  out  W  current (registered) state.
- undo_cnt  out  CW  number of valid undo steps, 0..DEPTH.
- undo_avail  out  1  undo_cnt != 0.

Behaviour:
- Reset (async, rst_n=0): game_state=0, all history=0, undo_cnt=0. Release is clean mid-operation; no op is pending.
- All updates occur on the rising clk edge with en=1. Outputs are registered, so there is 1-cycle latency from the strobe to the new game_state.
- LOAD:
  - game_state←state_init.
  - undo_cnt←0.
  - History contents become don't-care; they are never observable through game_state.
- PUSH_BM / PUSH_MM:
  - hist[0]←game_state, hist[i]←hist[i-1].
  - game_state←state_bm or state_mm respectively.
  - undo_cnt←min(undo_cnt+1, DEPTH). When full, the oldest entry is discarded.
- UNDO:
  - If undo_cnt>0: game_state←hist[0], hist[i]←hist[i+1], undo_cnt−1.
  - If undo_cnt==0: no state change (a silent no-op, unlike the predecessor).
- en=0: every register holds.
- Implementation may be a shift chain or a ring with a head pointer. Externally only the above order is visible.
- The block performs no arithmetic on state data. The counter saturates at both ends and never wraps.

Optional Feature:
- GAME_UNDO_REDO_EN.
- When defined:
  - Adds input redo (1) and output redo_cnt (CW).
  - A second stack of depth DEPTH records states removed by UNDO: the undone game_state is pushed onto the redo stack.
  - When en=1 and redo=1 and redo_cnt>0: game_state←redo top, the current state is pushed onto the undo history (saturating as in PUSH), and redo_cnt−1. sel is ignored that cycle.
  - redo with redo_cnt==0 is a no-op.
  - Any PUSH or LOAD clears redo_cnt to 0.
  - Reset clears redo_cnt.
- When undefined: no redo port or logic; behaviour is exactly as above.

Decomposition:
- Package game_pkg holds:
  - op codes OP_LOAD / OP_PUSH_BM / OP_PUSH_MM / OP_UNDO (2-bit);
  - localparam GAME_STATE_W=134;
  - GAME_UNDO_DEPTH default 3.
- One sub-module, game_hist_stack:
  - a W×DEPTH LIFO with push, pop, clear, saturating count, and drop-oldest on full push.
  - Instantiated once for undo, and once more for redo under the macro.

Test Plan (W=8, DEPTH=3 unless stated):
- Reset, then release → game_state=0x00, undo_cnt=0, undo_avail=0. Assert rst_n low mid-push → outputs return to 0 immediately without waiting for clk.
- LOAD 0x10; PUSH_MM 0x11; PUSH_BM 0x12 → game_state=0x12, undo_cnt=2. UNDO twice → 0x11 then 0x10, undo_cnt=0.
- From LOAD 0x10: PUSH 0x11, 0x12, 0x13, 0x14 → undo_cnt saturates at 3. UNDO×3 → 0x13, 0x12, 0x11. Fourth UNDO → stays 0x11, cnt 0.
- UNDO right after LOAD 0x20 → game_state stays 0x20, undo_cnt 0. Any op with en=0 → no change.
- LOAD 0x30; PUSH 0x31; UNDO; PUSH 0x32 → game_state 0x32, undo_cnt=1. UNDO → 0x30.
- GAME_UNDO_REDO_EN: LOAD 0x40; PUSH 0x41; PUSH 0x42; UNDO; UNDO; redo → 0x41, redo_cnt=1; redo → 0x42, redo_cnt=0. UNDO; PUSH 0x50; redo → stays 0x50.
